// File: rtl/vx_fpu_csr_bank.sv
// -----------------------------------------------------------------------------
// vx_fpu_csr_bank
//
// Per-warp floating-point CSR storage (fflags, frm, fcsr) sitting on the CSR
// side of the FPU-to-CSR link. NUM_PORTS FPU channels may post sticky
// exception flags every cycle and read their warp's rounding mode
// combinationally. The core's CSR unit reaches the same registers through a
// one-deep, back-pressured request/response port.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   fpu_write_*       per-channel flag posts (enable, warp id, flags)
//   fpu_read_wid/frm  per-channel rounding-mode lookup (combinational)
//   csr_req_*         CSR request: valid/ready, write, wid, addr, data
//   csr_rsp_*         CSR response: valid/ready, data (old CSR value)
//
// Handshake: a request transfers on a cycle with csr_req_valid & csr_req_ready;
// a response transfers on a cycle with csr_rsp_valid & csr_rsp_ready. The
// response register is the only buffer, so a new request is taken only when
// that register is empty or being drained in the same cycle. Once raised,
// csr_rsp_valid and csr_rsp_data hold until the response transfers.
// -----------------------------------------------------------------------------
module vx_fpu_csr_bank #(
    parameter int NUM_WARPS   = 4,
    parameter int NUM_PORTS   = 2,
    parameter int NW_BITS     = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
    parameter int FFLAGS_BITS = 5,
    parameter int FRM_BITS    = 3
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_PORTS-1:0]             fpu_write_enable,
    input  logic [NUM_PORTS*NW_BITS-1:0]     fpu_write_wid,
    input  logic [NUM_PORTS*FFLAGS_BITS-1:0] fpu_write_fflags,
    input  logic [NUM_PORTS*NW_BITS-1:0]     fpu_read_wid,
    output logic [NUM_PORTS*FRM_BITS-1:0]    fpu_read_frm,
    input  logic                             csr_req_valid,
    output logic                             csr_req_ready,
    input  logic                             csr_req_write,
    input  logic [NW_BITS-1:0]               csr_req_wid,
    input  logic [11:0]                      csr_req_addr,
    input  logic [31:0]                      csr_req_data,
    output logic                             csr_rsp_valid,
    input  logic                             csr_rsp_ready,
    output logic [31:0]                      csr_rsp_data
);

    localparam logic [11:0] ADDR_FFLAGS = 12'h001;
    localparam logic [11:0] ADDR_FRM    = 12'h002;
    localparam logic [11:0] ADDR_FCSR   = 12'h003;

    logic [FFLAGS_BITS-1:0] fflags     [NUM_WARPS];
    logic [FRM_BITS-1:0]    frm        [NUM_WARPS];
    logic [FFLAGS_BITS-1:0] fflags_nxt [NUM_WARPS];
    logic [FRM_BITS-1:0]    frm_nxt    [NUM_WARPS];
    logic [FFLAGS_BITS-1:0] merge      [NUM_WARPS];

    logic        req_fire;
    logic        hit_fflags;
    logic        hit_frm;
    logic        hit_fcsr;
    logic [31:0] rd_data;

    // Upper write-data bits have no destination in these CSRs.
    logic unused_data;
    assign unused_data = ^csr_req_data[31:FFLAGS_BITS+FRM_BITS];

    assign csr_req_ready = !csr_rsp_valid || csr_rsp_ready;
    assign req_fire      = csr_req_valid && csr_req_ready;

    assign hit_fflags = (csr_req_addr == ADDR_FFLAGS);
    assign hit_frm    = (csr_req_addr == ADDR_FRM);
    assign hit_fcsr   = (csr_req_addr == ADDR_FCSR);

    // OR together every channel's post per warp so no flag is lost when
    // several channels hit the same warp in one cycle.
    always_comb begin
        for (int w = 0; w < NUM_WARPS; w++) begin
            merge[w] = '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (fpu_write_enable[p]
                    && (fpu_write_wid[p*NW_BITS +: NW_BITS] == NW_BITS'(w))) begin
                    merge[w] = merge[w] | fpu_write_fflags[p*FFLAGS_BITS +: FFLAGS_BITS];
                end
            end
        end
    end

    // Next-state: a CSR write replaces the stored flags, but the same-cycle
    // FPU merge is still OR-ed in so a software clear never hides a new
    // exception.
    always_comb begin
        for (int w = 0; w < NUM_WARPS; w++) begin
            fflags_nxt[w] = fflags[w] | merge[w];
            frm_nxt[w]    = frm[w];
            if (req_fire && csr_req_write && (csr_req_wid == NW_BITS'(w))) begin
                if (hit_fflags || hit_fcsr) begin
                    fflags_nxt[w] = csr_req_data[FFLAGS_BITS-1:0] | merge[w];
                end
                if (hit_frm) begin
                    frm_nxt[w] = csr_req_data[FRM_BITS-1:0];
                end
                if (hit_fcsr) begin
                    frm_nxt[w] = csr_req_data[FFLAGS_BITS +: FRM_BITS];
                end
            end
        end
    end

    // Response carries the value before this cycle's update; unknown
    // addresses read as zero.
    always_comb begin
        rd_data = '0;
        if (hit_fflags) begin
            rd_data[FFLAGS_BITS-1:0] = fflags[csr_req_wid];
        end else if (hit_frm) begin
            rd_data[FRM_BITS-1:0] = frm[csr_req_wid];
        end else if (hit_fcsr) begin
            rd_data[FRM_BITS+FFLAGS_BITS-1:0] = {frm[csr_req_wid], fflags[csr_req_wid]};
        end
    end

    always_comb begin
        fpu_read_frm = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            fpu_read_frm[p*FRM_BITS +: FRM_BITS] = frm[fpu_read_wid[p*NW_BITS +: NW_BITS]];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                fflags[w] <= '0;
                frm[w]    <= '0;
            end
            csr_rsp_valid <= 1'b0;
            csr_rsp_data  <= '0;
        end else begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                fflags[w] <= fflags_nxt[w];
                frm[w]    <= frm_nxt[w];
            end
            if (req_fire) begin
                csr_rsp_valid <= 1'b1;
                csr_rsp_data  <= rd_data;
            end else if (csr_rsp_ready) begin
                csr_rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vx_fpu_csr_bank.sv
module tb_vx_fpu_csr_bank;

  localparam int NW = 4;
  localparam int NP = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  fpu_write_enable = '0;
  logic [3:0]  fpu_write_wid = '0;
  logic [9:0]  fpu_write_fflags = '0;
  logic [3:0]  fpu_read_wid = '0;
  logic [5:0]  fpu_read_frm;
  logic        csr_req_valid = 1'b0;
  logic        csr_req_ready;
  logic        csr_req_write = 1'b0;
  logic [1:0]  csr_req_wid = '0;
  logic [11:0] csr_req_addr = '0;
  logic [31:0] csr_req_data = '0;
  logic        csr_rsp_valid;
  logic        csr_rsp_ready = 1'b1;
  logic [31:0] csr_rsp_data;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  vx_fpu_csr_bank dut (
    .clk              (clk),
    .reset            (reset),
    .fpu_write_enable (fpu_write_enable),
    .fpu_write_wid    (fpu_write_wid),
    .fpu_write_fflags (fpu_write_fflags),
    .fpu_read_wid     (fpu_read_wid),
    .fpu_read_frm     (fpu_read_frm),
    .csr_req_valid    (csr_req_valid),
    .csr_req_ready    (csr_req_ready),
    .csr_req_write    (csr_req_write),
    .csr_req_wid      (csr_req_wid),
    .csr_req_addr     (csr_req_addr),
    .csr_req_data     (csr_req_data),
    .csr_rsp_valid    (csr_rsp_valid),
    .csr_rsp_ready    (csr_rsp_ready),
    .csr_rsp_data     (csr_rsp_data)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // behavioural model: register arrays plus a queue of owed responses
  logic [4:0]  m_fflags[NW];
  logic [2:0]  m_frm[NW];
  logic [31:0] exp_q[$];
  logic [4:0]  m_merge[NW];
  logic [31:0] m_old;
  bit          m_acc;

  always @(posedge clk) begin
    if (reset) begin
      for (int w = 0; w < NW; w++) begin
        m_fflags[w] = '0;
        m_frm[w] = '0;
      end
      exp_q.delete();
    end else begin
      for (int w = 0; w < NW; w++) m_merge[w] = '0;
      for (int p = 0; p < NP; p++)
        if (fpu_write_enable[p])
          m_merge[fpu_write_wid[p*2 +: 2]] |= fpu_write_fflags[p*5 +: 5];
      m_acc = csr_req_valid && (exp_q.size() == 0 || csr_rsp_ready);
      if (exp_q.size() != 0 && csr_rsp_ready) void'(exp_q.pop_front());
      if (m_acc) begin
        case (csr_req_addr)
          12'h001: m_old = 32'(m_fflags[csr_req_wid]);
          12'h002: m_old = 32'(m_frm[csr_req_wid]);
          12'h003: m_old = 32'(m_frm[csr_req_wid]) * 32 + 32'(m_fflags[csr_req_wid]);
          default: m_old = 0;
        endcase
        exp_q.push_back(m_old);
        if (csr_req_write) begin
          if (csr_req_addr == 12'h001) m_fflags[csr_req_wid] = csr_req_data[4:0];
          if (csr_req_addr == 12'h002) m_frm[csr_req_wid] = csr_req_data[2:0];
          if (csr_req_addr == 12'h003) begin
            m_frm[csr_req_wid] = csr_req_data[7:5];
            m_fflags[csr_req_wid] = csr_req_data[4:0];
          end
        end
      end
      for (int w = 0; w < NW; w++) m_fflags[w] |= m_merge[w];
    end
  end

  // compare process: every cycle, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("req_ready", 32'(csr_req_ready), 32'(exp_q.size() == 0 || csr_rsp_ready));
      check("rsp_valid", 32'(csr_rsp_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) check("rsp_data", csr_rsp_data, exp_q[0]);
      for (int p = 0; p < NP; p++)
        check("fpu_read_frm", 32'(fpu_read_frm[p*3 +: 3]), 32'(m_frm[fpu_read_wid[p*2 +: 2]]));
    end
  end

  // driver: one CSR transaction, called at posedge+1, returns aligned likewise
  task automatic csr_txn(input logic wr, input logic [1:0] wid, input logic [11:0] addr,
                         input logic [31:0] data, output logic [31:0] rd);
    bit acc = 1'b0;
    csr_req_valid = 1'b1;
    csr_req_write = wr;
    csr_req_wid   = wid;
    csr_req_addr  = addr;
    csr_req_data  = data;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      acc = csr_req_ready;
      @(posedge clk); #1;
    end
    csr_req_valid = 1'b0;
    check("txn_accept", 32'(acc), 32'd1);
    rd = '0;
    if (acc) begin
      @(negedge clk);
      check("txn_rsp_valid", 32'(csr_rsp_valid), 32'd1);
      rd = csr_rsp_data;
      @(posedge clk); #1;
    end
  endtask

  logic [31:0] r;
  int acc_cnt;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    reset = 1'b0;

    // reset state
    csr_txn(1'b0, 2'd2, 12'h003, 32'h0, r);
    check("reset_fcsr_w2", r, 32'h0);
    check("reset_frm_ports", 32'(fpu_read_frm), 32'h0);

    // simultaneous posts to one warp, then a further post
    fpu_write_enable = 2'b11;
    fpu_write_wid    = {2'd1, 2'd1};
    fpu_write_fflags = {5'h10, 5'h01};
    @(posedge clk); #1;
    fpu_write_enable = 2'b01;
    fpu_write_fflags = {5'h00, 5'h04};
    @(posedge clk); #1;
    fpu_write_enable = 2'b00;
    csr_txn(1'b0, 2'd1, 12'h001, 32'h0, r);
    check("merge_fflags_w1", r, 32'h15);
    for (int w = 0; w < NW; w += 2) begin
      csr_txn(1'b0, 2'(w), 12'h001, 32'h0, r);
      check("other_warp_zero", r, 32'h0);
    end
    csr_txn(1'b0, 2'd3, 12'h001, 32'h0, r);
    check("other_warp_zero", r, 32'h0);

    // fcsr write, frm visibility on next cycle
    fpu_read_wid = {2'd3, 2'd3};
    @(negedge clk);
    check("frm_before_write", 32'(fpu_read_frm[2:0]), 32'h0);
    @(posedge clk); #1;
    csr_txn(1'b1, 2'd3, 12'h003, 32'hE3, r);
    check("fcsr_write_old", r, 32'h0);
    @(negedge clk);
    check("frm_after_write", 32'(fpu_read_frm[2:0]), 32'h7);
    check("frm_after_write_p1", 32'(fpu_read_frm[5:3]), 32'h7);
    @(posedge clk); #1;
    csr_txn(1'b0, 2'd3, 12'h003, 32'h0, r);
    check("fcsr_readback_w3", r, 32'hE3);

    // CSR clear colliding with an FPU post
    fpu_write_enable = 2'b10;
    fpu_write_wid    = {2'd0, 2'd0};
    fpu_write_fflags = {5'h08, 5'h00};
    csr_txn(1'b1, 2'd0, 12'h001, 32'h0, r);
    fpu_write_enable = 2'b00;
    csr_txn(1'b0, 2'd0, 12'h001, 32'h0, r);
    check("clear_vs_post_w0", r, 32'h08);

    // back-pressure
    csr_rsp_ready = 1'b0;
    csr_req_valid = 1'b1;
    csr_req_write = 1'b0;
    csr_req_wid   = 2'd1;
    csr_req_addr  = 12'h001;
    acc_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (csr_req_ready) acc_cnt++;
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("bp_accepts", 32'(acc_cnt), 32'd1);
    check("bp_req_ready", 32'(csr_req_ready), 32'd0);
    check("bp_rsp_data", csr_rsp_data, 32'h15);
    @(posedge clk); #1;
    csr_rsp_ready = 1'b1;
    acc_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      csr_req_wid  = 2'(i);
      csr_req_addr = 12'(1 + (i % 3));
      @(negedge clk);
      if (csr_req_ready) acc_cnt++;
      @(posedge clk); #1;
    end
    csr_req_valid = 1'b0;
    check("burst_accepts", 32'(acc_cnt), 32'd4);
    @(posedge clk); #1;

    // unknown address
    csr_txn(1'b1, 2'd3, 12'h7C0, 32'hFFFF_FFFF, r);
    check("unknown_addr", r, 32'h0);
    csr_txn(1'b0, 2'd3, 12'h003, 32'h0, r);
    check("unknown_no_effect", r, 32'hE3);

    // reset with a pending response
    csr_rsp_ready = 1'b0;
    csr_req_valid = 1'b1;
    csr_req_write = 1'b0;
    csr_req_wid   = 2'd3;
    csr_req_addr  = 12'h003;
    @(posedge clk); #1;
    csr_req_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_rsp_valid", 32'(csr_rsp_valid), 32'd0);
    check("rst_rsp_data", csr_rsp_data, 32'd0);
    check("rst_frm", 32'(fpu_read_frm), 32'd0);
    @(posedge clk); #1;
    csr_rsp_ready = 1'b1;
    csr_txn(1'b0, 2'd3, 12'h003, 32'h0, r);
    check("rst_fcsr_w3", r, 32'h0);
    csr_txn(1'b0, 2'd1, 12'h001, 32'h0, r);
    check("rst_fflags_w1", r, 32'h0);

    // randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      fpu_write_enable = 2'($urandom_range(0, 3));
      fpu_write_wid    = 4'($urandom_range(0, 15));
      fpu_write_fflags = 10'($urandom_range(0, 1023));
      fpu_read_wid     = 4'($urandom_range(0, 15));
      csr_req_valid    = ($urandom_range(0, 1) == 1);
      csr_req_write    = ($urandom_range(0, 9) < 3);
      csr_req_wid      = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 7))
        0: csr_req_addr = 12'($urandom_range(0, 4095));
        1, 2: csr_req_addr = 12'h001;
        3, 4: csr_req_addr = 12'h002;
        default: csr_req_addr = 12'h003;
      endcase
      csr_req_data     = $urandom;
      csr_rsp_ready    = ($urandom_range(0, 9) < 7);
      reset            = ($urandom_range(0, 199) == 0);
      @(posedge clk); #1;
    end
    reset = 1'b0;
    csr_req_valid = 1'b0;
    fpu_write_enable = '0;
    csr_rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vx_fpu_csr_bank.md
Name: vx_fpu_csr_bank

Overview:
- Per-warp floating-point CSR storage (fflags, frm, fcsr) on the CSR side of the FPU-to-CSR link.
- Generalises the single-channel FPU link to NUM_PORTS independent FPU channels. Each channel can post sticky exception flags and read its warp's rounding mode every cycle.
- Provides a pipelined, back-pressured CSR access port for the core's CSR unit, with FPU flag merging on write collisions.

Parameters:
- NUM_WARPS, 4, number of warps; one fflags/frm register set per warp.
- NUM_PORTS, 2, number of FPU write/read channels.
- NW_BITS, $clog2(NUM_WARPS) (minimum 1), warp id width.
- FFLAGS_BITS, 5, exception flag width; bit order NV[4] DZ[3] OF[2] UF[1] NX[0].
- FRM_BITS, 3, rounding mode width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- fpu_write_enable  in  NUM_PORTS  per-channel flag-post strobe
- fpu_write_wid  in  NUM_PORTS*NW_BITS  per-channel warp id
- fpu_write_fflags  in  NUM_PORTS*FFLAGS_BITS  per-channel flags to accumulate
- fpu_read_wid  in  NUM_PORTS*NW_BITS  per-channel warp id for frm lookup
- fpu_read_frm  out  NUM_PORTS*FRM_BITS  frm of the addressed warp, combinational
- csr_req_valid  in  1  CSR request valid
- csr_req_ready  out  1  CSR request accepted this cycle
- csr_req_write  in  1  1 = write, 0 = read
- csr_req_wid  in  NW_BITS  target warp
- csr_req_addr  in  12  CSR address: 0x001 fflags, 0x002 frm, 0x003 fcsr
- csr_req_data  in  32  write data
- csr_rsp_valid  out  1  response valid
- csr_rsp_ready  in  1  response consumed
- csr_rsp_data  out  32  old CSR value, zero-extended

Behaviour:
- Reset, synchronous and active-high, applied on a clk edge with reset=1:
  - all fflags[w] and frm[w] go to 0 (RNE).
  - csr_rsp_valid and csr_rsp_data go to 0.
  - A pending response is dropped.
  - fpu_read_frm reads 0 from the next cycle.
- Both accept conditions hold in the same cycle as reset; nothing is written while reset=1.
- FPU flag accumulation:
  - Each cycle, for each warp w, merge = OR of fpu_write_fflags[p] over all p with fpu_write_enable[p] and fpu_write_wid[p]==w.
  - fflags[w] <= fflags[w] | merge.
  - Any number of channels may target the same warp in one cycle; no flag is lost.
  - Posts are always accepted; there is no back-pressure on the FPU side.
- FPU frm read:
  - fpu_read_frm[p] = frm[fpu_read_wid[p]], combinational from the registers.
  - A CSR write to frm in cycle N is visible on fpu_read_frm from cycle N+1.
- CSR request handshake:
  - csr_req_ready = !csr_rsp_valid | csr_rsp_ready.
  - A request is accepted when csr_req_valid & csr_req_ready.
  - An accepted request in cycle N produces csr_rsp_valid=1 in cycle N+1.
  - The response holds stable until csr_rsp_valid & csr_rsp_ready.
  - Back-to-back accepts are allowed, giving a throughput of 1 per cycle while rsp_ready=1.
- CSR response data is the register value before the cycle-N update; same-cycle FPU posts are not included:
  - fflags: {27'b0, fflags[wid]}
  - frm: {29'b0, frm[wid]}
  - fcsr: {24'b0, frm[wid], fflags[wid]}
- CSR write, applied at the accepting edge:
  - fflags: fflags[wid] <= data[4:0] | merge[wid].
  - frm: frm[wid] <= data[2:0]. Reserved values 5–7 are stored unchanged.
  - fcsr: frm[wid] <= data[7:5]; fflags[wid] <= data[4:0] | merge[wid].
  - A same-cycle FPU post to the same warp is always OR-ed in; a CSR clear never cancels a coincident exception.
- Unknown address: response is returned with data 0; no state change.
- Accepted reads have no side effects. Requests that are not accepted have no effect.

Test Plan:
- Reset, then CSR read fcsr on wid 2 → rsp one cycle after accept, data 0x00. fpu_read_frm of all ports = 0.
- Port0 posts wid1 flags 0x01 and port1 posts wid1 flags 0x10 in the same cycle; next cycle port0 posts wid1 0x04 → read fflags wid1 returns 0x15. Other warps stay 0.
- CSR write fcsr wid3 data 0xE3 in cycle N → fpu_read_frm for wid3 is old value 0 in N and 7 from N+1. Read fcsr wid3 returns 0xE3. rsp of the write returns old value 0x00.
- CSR write fflags wid0 data 0x00 while port1 posts wid0 0x08 in the same cycle → read fflags wid0 returns 0x08.
- Hold csr_rsp_ready=0 with req_valid=1 continuously → exactly one accept, req_ready=0 thereafter. rsp_data is stable. Raising rsp_ready gives one-per-cycle accepts and in-order responses.
- Read addr 0x7C0 → rsp data 0, no state change. Assert reset with rsp_valid=1 → rsp_valid=0 next cycle and all registers 0.
